// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int SS_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ss_state_e;

endpackage

// File: rtl/fs_cell.sv
// One-bit combinational full-subtractor cell: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, one bit per clock, valid/ready on both sides.
// Optional signed-overflow output ovf_o is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  ss_state_e        state;
  ss_state_e        state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] d_ins;
  logic             borrow;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;

  assign accept   = in_valid && (state == ST_IDLE);
  assign last_bit = (count == CW'(WIDTH - 1));

  fs_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last_bit)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
  always_comb begin
    d_ins            = '0;
    d_ins[WIDTH-1]   = cell_d;
    diff_next        = (diff_sr >> 1) | d_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      count   <= '0;
    end else if (accept) begin
      a_sr   <= a_i;
      b_sr   <= b_i;
      borrow <= bin_i;
      count  <= '0;
    end else if (state == ST_RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_next;
      borrow  <= cell_bo;
      count   <= count + CW'(1);
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign diff_o    = diff_sr;
  assign bout_o    = borrow;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_msb <= a_i[WIDTH-1];
      b_msb <= b_i[WIDTH-1];
    end
  end

  assign ovf_o = (a_msb != b_msb) && (diff_sr[WIDTH-1] != a_msb);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed/random plus WIDTH=3 exhaustive.
// Checks ovf_o as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, iv8, ir8, bin8, ov8, or8, bo8;
  logic [7:0] a8, b8, d8;
  logic       rst3_n, iv3, ir3, bin3, ov3, or3, bo3;
  logic [2:0] a3, b3, d3;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf3;
`endif

  exp_t exp8_q[$];
  exp_t exp3_q[$];
  exp_t e8, e3;
  int   vectors = 0;
  int   miscompares = 0;
  logic done3 = 1'b0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .a_i(a8), .b_i(b8), .bin_i(bin8), .out_valid(ov8), .out_ready(or8),
    .diff_o(d8), .bout_o(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf_o(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in_ready(ir3),
    .a_i(a3), .b_i(b3), .bin_i(bin3), .out_valid(ov3), .out_ready(or3),
    .diff_o(d3), .bout_o(bo3)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf_o(ovf3)
`endif
  );

  // Reference: integer subtraction, borrow = negative result, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int   mask, full;
    mask   = (1 << w) - 1;
    full   = (int'(a) & mask) - (int'(b) & mask) - int'(bin);
    e.bout = (full < 0);
    e.diff = 8'(full & mask);
    e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply_stimulus8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1;
    @(negedge clk);
    while (!ir8 && n < 100) begin @(negedge clk); n++; end
    check_output("accept8_wait", int'(n < 100), 1);
    exp8_q.push_back(model(8, a, b, bin));
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic apply_stimulus3(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n = 0;
    @(posedge clk); #1;
    a3 = a[2:0]; b3 = b[2:0]; bin3 = bin; iv3 = 1'b1;
    @(negedge clk);
    while (!ir3 && n < 100) begin @(negedge clk); n++; end
    check_output("accept3_wait", int'(n < 100), 1);
    exp3_q.push_back(model(3, a, b, bin));
    @(posedge clk); #1;
    iv3 = 1'b0;
  endtask

  // Directed run on the 8-bit DUT: checks latency and the spec's literal results.
  task automatic run_directed8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input logic [7:0] exp_diff, input logic exp_bout, input logic exp_ovf);
    int n = 0;
    apply_stimulus8(a, b, bin);
    do begin @(posedge clk); #1; n++; end while (!ov8 && n < 40);
    check_output("latency8", n, 8);
    check_output("dir_diff8", d8, exp_diff);
    check_output("dir_bout8", bo8, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
    check_output("dir_ovf8", ovf8, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("[TB] note: unknown ovf expectation");
`endif
  endtask

  always @(negedge clk) begin
    if (rst8_n && ov8 && or8) begin
      check_output("q8_has_entry", int'(exp8_q.size() > 0), 1);
      if (exp8_q.size() > 0) begin
        e8 = exp8_q.pop_front();
        check_output("diff8", d8, e8.diff);
        check_output("bout8", bo8, e8.bout);
`ifdef SERIAL_SUB_OVF_EN
        check_output("ovf8", ovf8, e8.ovf);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst3_n && ov3 && or3) begin
      check_output("q3_has_entry", int'(exp3_q.size() > 0), 1);
      if (exp3_q.size() > 0) begin
        e3 = exp3_q.pop_front();
        check_output("diff3", d3, e3.diff);
        check_output("bout3", bo3, e3.bout);
`ifdef SERIAL_SUB_OVF_EN
        check_output("ovf3", ovf3, e3.ovf);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst8_n = 1'b0; rst3_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; or8 = 1'b1;
    iv3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0; or3 = 1'b1;
    #12;
    check_output("rst_in_ready8", ir8, 1);
    check_output("rst_out_valid8", ov8, 0);
    check_output("rst_diff8", d8, 0);
    check_output("rst_bout8", bo8, 0);
    check_output("rst_in_ready3", ir3, 1);
    check_output("rst_out_valid3", ov3, 0);
`ifdef SERIAL_SUB_OVF_EN
    check_output("rst_ovf8", ovf8, 0);
`endif
    @(posedge clk); #1;
    rst8_n = 1'b1; rst3_n = 1'b1;

    $display("[TB] directed WIDTH=8 cases");
    run_directed8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_directed8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_directed8(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_directed8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    $display("[TB] backpressure");
    @(posedge clk); #1; or8 = 1'b0;
    apply_stimulus8(8'h37, 8'h12, 1'b0);
    n = 0;
    while (!ov8 && n < 40) begin @(negedge clk); n++; end
    check_output("bp_reach_done", int'(n < 40), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv8 = 1'b1; a8 = 8'h99; b8 = 8'h11; bin8 = 1'b0;
      @(negedge clk);
      check_output("bp_diff_stable", d8, 8'h25);
      check_output("bp_out_valid", ov8, 1);
      check_output("bp_in_ready", ir8, 0);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check_output("bp_release_out_valid", ov8, 0);
    check_output("bp_release_in_ready", ir8, 1);

    $display("[TB] reset during RUN");
    apply_stimulus8(8'h33, 8'h11, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    exp8_q.delete();
    #1;
    check_output("abort_out_valid", ov8, 0);
    check_output("abort_in_ready", ir8, 1);
    check_output("abort_diff", d8, 0);
    @(posedge clk); #1;
    rst8_n = 1'b1;
    run_directed8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    $display("[TB] random WIDTH=8 vectors");
    for (int i = 0; i < 24; i++)
      apply_stimulus8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] exhaustive WIDTH=3 with stalls");
    fork
      begin
        for (int k = 0; k < 128; k++)
          apply_stimulus3(8'(k[6:4]), 8'(k[3:1]), k[0]);
        done3 = 1'b1;
      end
      begin
        while (!done3) begin
          @(posedge clk); #1;
          or3 = ($urandom_range(0, 3) != 0);
        end
        or3 = 1'b1;
      end
    join

    n = 0;
    while ((exp3_q.size() != 0 || exp8_q.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    check_output("drain8", exp8_q.size(), 0);
    check_output("drain3", exp3_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
